// File: rtl/video_timing_pkg.sv
// Shared video timing package: 640x480@60 default constants and constant
// functions for the blanking start coordinate and total period lengths.
// Also used by the framebuffer read stage for its window constants.
package video_timing_pkg;

  // 640x480@60 horizontal timing (pixels)
  localparam int VT_H_ACTIVE = 640;
  localparam int VT_H_FRONT  = 16;
  localparam int VT_H_SYNC   = 96;
  localparam int VT_H_BACK   = 48;

  // 640x480@60 vertical timing (lines)
  localparam int VT_V_ACTIVE = 480;
  localparam int VT_V_FRONT  = 10;
  localparam int VT_V_SYNC   = 2;
  localparam int VT_V_BACK   = 33;

  // First (most negative) coordinate of a line/frame: the whole blanking
  // interval sits below zero so the active area starts at coordinate 0.
  function automatic int vt_start(input int front, input int sync_w, input int back);
    return -(front + sync_w + back);
  endfunction

  // Total period length (active plus blanking).
  function automatic int vt_total(input int active, input int front,
                                  input int sync_w, input int back);
    return active + front + sync_w + back;
  endfunction

  localparam int VT_H_START = vt_start(VT_H_FRONT, VT_H_SYNC, VT_H_BACK);              // -160
  localparam int VT_V_START = vt_start(VT_V_FRONT, VT_V_SYNC, VT_V_BACK);              // -45
  localparam int VT_H_TOTAL = vt_total(VT_H_ACTIVE, VT_H_FRONT, VT_H_SYNC, VT_H_BACK); // 800
  localparam int VT_V_TOTAL = vt_total(VT_V_ACTIVE, VT_V_FRONT, VT_V_SYNC, VT_V_BACK); // 525

endpackage

// File: rtl/video_timing_gen.sv
// Video timing generator: signed pixel coordinates (negative in blanking),
// hsync/vsync, data enable and line/frame start strobes. All outputs are
// registered and computed from the next counter values so they line up with
// o_x_pos/o_y_pos in the same cycle.
// Optional feature macro: VIDEO_TIMING_FRAME_CNT_EN adds a 16-bit frame counter.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int p_h_active    = VT_H_ACTIVE,
  parameter int p_h_front     = VT_H_FRONT,
  parameter int p_h_sync      = VT_H_SYNC,
  parameter int p_h_back      = VT_H_BACK,
  parameter int p_v_active    = VT_V_ACTIVE,
  parameter int p_v_front     = VT_V_FRONT,
  parameter int p_v_sync      = VT_V_SYNC,
  parameter int p_v_back      = VT_V_BACK,
  parameter bit p_h_sync_pol  = 1'b0,
  parameter bit p_v_sync_pol  = 1'b0,
  parameter int p_count_width = 16
) (
  input  logic                            i_clk_pixel,
  input  logic                            i_rst_n,
  output logic                            o_hsync,
  output logic                            o_vsync,
  output logic                            o_de,
  output logic                            o_frame,
  output logic                            o_line,
  output logic signed [p_count_width-1:0] o_x_pos,
  output logic signed [p_count_width-1:0] o_y_pos
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]                     o_frame_cnt
`endif
);

  // Integer-domain derived constants
  localparam int H_START_I  = vt_start(p_h_front, p_h_sync, p_h_back);
  localparam int V_START_I  = vt_start(p_v_front, p_v_sync, p_v_back);
  localparam int H_END_I    = p_h_active - 1;
  localparam int V_END_I    = p_v_active - 1;
  localparam int HS_FIRST_I = H_START_I + p_h_front;
  localparam int HS_LAST_I  = HS_FIRST_I + p_h_sync - 1;
  localparam int VS_FIRST_I = V_START_I + p_v_front;
  localparam int VS_LAST_I  = VS_FIRST_I + p_v_sync - 1;
  localparam int C_MIN_I    = -(1 << (p_count_width - 1));
  localparam int C_MAX_I    = (1 << (p_count_width - 1)) - 1;

  // Coordinate-width signed constants so every compare is signed at p_count_width
  localparam logic signed [p_count_width-1:0] L_H_START  = p_count_width'(H_START_I);
  localparam logic signed [p_count_width-1:0] L_V_START  = p_count_width'(V_START_I);
  localparam logic signed [p_count_width-1:0] L_H_END    = p_count_width'(H_END_I);
  localparam logic signed [p_count_width-1:0] L_V_END    = p_count_width'(V_END_I);
  localparam logic signed [p_count_width-1:0] L_HS_FIRST = p_count_width'(HS_FIRST_I);
  localparam logic signed [p_count_width-1:0] L_HS_LAST  = p_count_width'(HS_LAST_I);
  localparam logic signed [p_count_width-1:0] L_VS_FIRST = p_count_width'(VS_FIRST_I);
  localparam logic signed [p_count_width-1:0] L_VS_LAST  = p_count_width'(VS_LAST_I);
  localparam logic signed [p_count_width-1:0] L_ZERO     = '0;
  localparam logic signed [p_count_width-1:0] L_ONE      = p_count_width'(1);

  // Reject timings whose coordinates do not fit the signed counter width.
  if (H_START_I < C_MIN_I || V_START_I < C_MIN_I ||
      H_END_I > C_MAX_I || V_END_I > C_MAX_I) begin : g_range_check
    $fatal(1, "video_timing_gen: timing does not fit p_count_width");
  end

  logic signed [p_count_width-1:0] r_x_pos;
  logic signed [p_count_width-1:0] r_y_pos;
  logic                            r_hsync;
  logic                            r_vsync;
  logic                            r_de;
  logic                            r_frame;
  logic                            r_line;

  logic signed [p_count_width-1:0] w_x_next;
  logic signed [p_count_width-1:0] w_y_next;
  logic                            w_x_wrap;
  logic                            w_y_wrap;
  logic                            w_hs_active;
  logic                            w_vs_active;
  logic                            w_de_next;

  // Next coordinates and the flag values decoded from them
  always_comb begin
    w_x_wrap    = (r_x_pos == L_H_END);
    w_y_wrap    = (r_y_pos == L_V_END);
    w_x_next    = w_x_wrap ? L_H_START : (r_x_pos + L_ONE);
    w_y_next    = r_y_pos;
    if (w_x_wrap) begin
      w_y_next = w_y_wrap ? L_V_START : (r_y_pos + L_ONE);
    end
    w_hs_active = (w_x_next >= L_HS_FIRST) && (w_x_next <= L_HS_LAST);
    w_vs_active = (w_y_next >= L_VS_FIRST) && (w_y_next <= L_VS_LAST);
    w_de_next   = (w_x_next >= L_ZERO) && (w_y_next >= L_ZERO);
  end

  // Counter, sync, enable and strobe registers; reset parks at the frame start
  // without raising any strobe.
  always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x_pos <= L_H_START;
      r_y_pos <= L_V_START;
      r_hsync <= ~p_h_sync_pol;
      r_vsync <= ~p_v_sync_pol;
      r_de    <= 1'b0;
      r_frame <= 1'b0;
      r_line  <= 1'b0;
    end else begin
      r_x_pos <= w_x_next;
      r_y_pos <= w_y_next;
      r_hsync <= w_hs_active ? p_h_sync_pol : ~p_h_sync_pol;
      r_vsync <= w_vs_active ? p_v_sync_pol : ~p_v_sync_pol;
      r_de    <= w_de_next;
      r_line  <= w_x_wrap;
      r_frame <= w_x_wrap && w_y_wrap;
    end
  end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Frame counter steps during each o_frame cycle, so the value shown alongside
  // the n-th frame strobe is n-1; wraps naturally at 16 bits.
  always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= 16'd0;
    end else if (r_frame) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`endif

  assign o_x_pos = r_x_pos;
  assign o_y_pos = r_y_pos;
  assign o_hsync = r_hsync;
  assign o_vsync = r_vsync;
  assign o_de    = r_de;
  assign o_frame = r_frame;
  assign o_line  = r_line;

endmodule
